// File: rtl/audio_sampler.sv
// Audio capture front end: programmable sample tick, ADC hold, offset-binary to signed,
// 2^OSR_LOG2 averaging and a valid/ready output. Optional DC block: AUDIO_SAMPLER_DCBLOCK_EN.
module audio_sampler #(
  parameter int unsigned CLK_DIV  = 2083,
  parameter int unsigned IN_W     = 12,
  parameter int unsigned OUT_W    = 8,
  parameter int unsigned OSR_LOG2 = 0,
  parameter int unsigned DC_SHIFT = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [1:0]       rate_sel_in,
  input  logic             clear_in,
  input  logic [IN_W-1:0]  adc_data_in,
  input  logic             adc_valid_in,
  output logic             sample_tick_out,
  output logic [OUT_W-1:0] sample_out,
  output logic             sample_valid_out,
  input  logic             sample_ready_in,
  output logic             overrun_out
);

  localparam int unsigned CW = $clog2((CLK_DIV << 3) + 1);
  localparam int unsigned AW = IN_W + OSR_LOG2;
  localparam int unsigned SW = OSR_LOG2 + 1;

  if (CLK_DIV < 4 || OUT_W > IN_W || OSR_LOG2 > 4 || DC_SHIFT == 0) begin : g_bad_cfg
    $error("audio_sampler: unsupported parameter combination");
  end

  logic [CW-1:0]          r_cnt;
  logic [1:0]             r_rate;
  logic [1:0]             w_rate;
  logic [CW-1:0]          w_last;
  logic                   w_tick;
  logic [IN_W-1:0]        r_hold;
  logic signed [IN_W-1:0] r_conv;
  logic                   r_conv_vld;
  logic signed [AW-1:0]   r_acc;
  logic [SW-1:0]          r_sub;
  logic signed [AW-1:0]   w_conv_ext;
  logic signed [AW-1:0]   w_sum;
  logic signed [IN_W-1:0] w_avg;
  logic                   w_last_sub;
  logic                   w_result;
  logic signed [IN_W-1:0] w_y;
  logic                   w_y_vld;
  logic [OUT_W-1:0]       r_out;
  logic                   r_valid;
  logic                   r_ovr;

  // Rate select is taken live at count 0 and held for the rest of the period.
  assign w_rate          = (r_cnt == '0) ? rate_sel_in : r_rate;
  assign w_last          = CW'((CLK_DIV << w_rate) - 1);
  assign w_tick          = (r_cnt == w_last);
  assign sample_tick_out = w_tick;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_cnt  <= '0;
      r_rate <= 2'd0;
    end else begin
      r_rate <= w_rate;
      r_cnt  <= w_tick ? '0 : r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_hold <= {1'b1, {(IN_W-1){1'b0}}};
    end else if (adc_valid_in) begin
      r_hold <= adc_data_in;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_conv     <= '0;
      r_conv_vld <= 1'b0;
    end else begin
      r_conv_vld <= w_tick & ~clear_in;
      if (w_tick) begin
        r_conv <= {~r_hold[IN_W-1], r_hold[IN_W-2:0]};
      end
    end
  end

  assign w_conv_ext = AW'(r_conv);
  assign w_sum      = r_acc + w_conv_ext;
  assign w_avg      = IN_W'(w_sum >>> OSR_LOG2);
  assign w_last_sub = (r_sub == SW'((1 << OSR_LOG2) - 1));
  assign w_result   = r_conv_vld & w_last_sub & ~clear_in;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_acc <= '0;
      r_sub <= '0;
    end else if (clear_in) begin
      r_acc <= '0;
      r_sub <= '0;
    end else if (r_conv_vld) begin
      if (w_last_sub) begin
        r_acc <= '0;
        r_sub <= '0;
      end else begin
        r_acc <= w_sum;
        r_sub <= r_sub + 1'b1;
      end
    end
  end

`ifdef AUDIO_SAMPLER_DCBLOCK_EN
  localparam int unsigned DW     = IN_W + DC_SHIFT;
  localparam int unsigned DIFF_W = IN_W + 1;
  localparam int unsigned SUM_W  = DW + 1;

  logic signed [IN_W-1:0]   r_avg;
  logic                     r_avg_vld;
  logic signed [DW-1:0]     r_dc_acc;
  logic signed [IN_W-1:0]   w_est;
  logic signed [DIFF_W-1:0] w_diff;
  logic signed [SUM_W-1:0]  w_dc_sum;
  logic signed [DW-1:0]     w_dc_next;

  assign w_est    = IN_W'(r_dc_acc >>> DC_SHIFT);
  assign w_diff   = DIFF_W'(r_avg) - DIFF_W'(w_est);
  assign w_dc_sum = SUM_W'(r_dc_acc) + SUM_W'(w_diff);
  assign w_y_vld  = r_avg_vld;

  // Both the output and the estimator accumulator saturate instead of wrapping.
  always_comb begin
    w_y       = w_diff[IN_W-1:0];
    w_dc_next = w_dc_sum[DW-1:0];
    if (w_diff[IN_W] != w_diff[IN_W-1]) begin
      w_y = w_diff[IN_W] ? {1'b1, {(IN_W-1){1'b0}}} : {1'b0, {(IN_W-1){1'b1}}};
    end
    if (w_dc_sum[DW] != w_dc_sum[DW-1]) begin
      w_dc_next = w_dc_sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_avg     <= '0;
      r_avg_vld <= 1'b0;
      r_dc_acc  <= '0;
    end else begin
      r_avg_vld <= w_result;
      if (w_result) begin
        r_avg <= w_avg;
      end
      if (r_avg_vld && !clear_in) begin
        r_dc_acc <= w_dc_next;
      end
    end
  end
`else
  assign w_y     = w_avg;
  assign w_y_vld = w_result;
`endif

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_out   <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else if (clear_in) begin
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else if (w_y_vld) begin
      r_out   <= OUT_W'(w_y >>> (IN_W - OUT_W));
      r_valid <= 1'b1;
      if (r_valid && !sample_ready_in) begin
        r_ovr <= 1'b1;
      end
    end else if (r_valid && sample_ready_in) begin
      r_valid <= 1'b0;
    end
  end

  assign sample_out       = r_out;
  assign sample_valid_out = r_valid;
  assign overrun_out      = r_ovr;

endmodule

// File: tb/tb_audio_sampler.sv
// Randomised bench for audio_sampler (default build) against a list-based reference model.
module tb_audio_sampler;

  localparam int unsigned CLK_DIV  = 4;
  localparam int unsigned IN_W     = 12;
  localparam int unsigned OUT_W    = 8;
  localparam int unsigned OSR_LOG2 = 2;
  localparam int unsigned DC_SHIFT = 8;
  localparam int          NSUB     = 1 << OSR_LOG2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       rate_sel = 2'd0;
  logic             clear = 1'b0;
  logic [IN_W-1:0]  adc_data = '0;
  logic             adc_valid = 1'b0;
  logic             tick;
  logic [OUT_W-1:0] sample;
  logic             sample_valid;
  logic             ready = 1'b1;
  logic             overrun;

  audio_sampler #(
    .CLK_DIV (CLK_DIV),
    .IN_W    (IN_W),
    .OUT_W   (OUT_W),
    .OSR_LOG2(OSR_LOG2),
    .DC_SHIFT(DC_SHIFT)
  ) dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .rate_sel_in     (rate_sel),
    .clear_in        (clear),
    .adc_data_in     (adc_data),
    .adc_valid_in    (adc_valid),
    .sample_tick_out (tick),
    .sample_out      (sample),
    .sample_valid_out(sample_valid),
    .sample_ready_in (ready),
    .overrun_out     (overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: absolute cycle numbers, a queue of captured sub-samples waiting to be
  // summed, and the observable output state.
  int         cyc = 0;
  int         period_start;
  int         next_tick;
  bit         m_tick;
  int         pipe_t[$];
  int         pipe_v[$];
  int         part_sum;
  int         part_cnt;
  int         held;
  logic [7:0] m_out;
  bit         m_valid;
  bit         m_ovr;

  task automatic model_reset();
    pipe_t.delete();
    pipe_v.delete();
    part_sum     = 0;
    part_cnt     = 0;
    held         = 0;
    m_out        = '0;
    m_valid      = 0;
    m_ovr        = 0;
    period_start = cyc;
    next_tick    = -1;
  endtask

  task automatic model_update();
    bit res_ok;
    int res;
    int v;
    int t;
    res_ok = 0;
    res    = 0;
    if (clear) begin
      part_sum = 0;
      part_cnt = 0;
      while (pipe_t.size() > 0 && pipe_t[0] <= cyc) begin
        t = pipe_t.pop_front();
        v = pipe_v.pop_front();
      end
    end else if (pipe_t.size() > 0 && pipe_t[0] == cyc) begin
      t = pipe_t.pop_front();
      v = pipe_v.pop_front();
      part_sum += v;
      part_cnt++;
      if (part_cnt == NSUB) begin
        res      = part_sum >>> OSR_LOG2;
        res_ok   = 1;
        part_sum = 0;
        part_cnt = 0;
      end
    end
    if (m_tick && !clear) begin
      pipe_t.push_back(cyc + 1);
      pipe_v.push_back(held);
    end
    if (clear) begin
      m_valid = 0;
      m_ovr   = 0;
    end else if (res_ok) begin
      if (m_valid && !ready) m_ovr = 1;
      m_out   = 8'((res >>> (IN_W - OUT_W)) & 'hFF);
      m_valid = 1;
    end else if (m_valid && ready) begin
      m_valid = 0;
    end
    if (adc_valid) held = int'(adc_data) - (1 << (IN_W - 1));
    if (m_tick) period_start = cyc + 1;
  endtask

  // Called just after a falling edge with this cycle's inputs already driven.
  task automatic step();
    if (cyc == period_start) next_tick = cyc + (CLK_DIV << rate_sel) - 1;
    m_tick = (cyc == next_tick);
    #1;
    check("tick", 32'(tick), 32'(m_tick));
    @(posedge clk);
    model_update();
    cyc++;
    @(negedge clk);
    check("valid", 32'(sample_valid), 32'(m_valid));
    check("sample", 32'(sample), 32'(m_out));
    check("overrun", 32'(overrun), 32'(m_ovr));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_sample", 32'(sample), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    @(posedge clk);
    @(posedge clk);
    cyc += 2;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [IN_W-1:0] seq [4];
    seq[0] = 12'h900;
    seq[1] = 12'h900;
    seq[2] = 12'hA00;
    seq[3] = 12'hA00;
    @(negedge clk);
    do_reset();

    // Four sub-samples averaged, then an overwrite while stalled, then a clear.
    ready     = 1'b0;
    adc_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      adc_data = seq[k];
      run(4);
    end
    run(4);
    check("avg_valid", 32'(sample_valid), 32'd1);
    check("avg_value", 32'(sample), 32'h18);
    run(16);
    check("ovr_value", 32'(sample), 32'h20);
    check("ovr_flag", 32'(overrun), 32'd1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clr_valid", 32'(sample_valid), 32'd0);
    check("clr_overrun", 32'(overrun), 32'd0);

    // Rate change mid-period and the extreme ADC codes.
    ready    = 1'b1;
    adc_data = 12'hFFF;
    run(2);
    rate_sel = 2'd2;
    run(40);
    rate_sel = 2'd0;
    adc_data = 12'h000;
    run(24);

    // Reset part-way through an average.
    do_reset();
    adc_data = 12'h800;
    run(8);
    do_reset();
    adc_data = 12'h3C5;
    run(24);

    // Randomised traffic.
    for (int i = 0; i < 5000; i++) begin
      adc_valid = ($urandom_range(0, 2) == 0);
      adc_data  = IN_W'($urandom);
      ready     = ($urandom_range(0, 3) != 0);
      clear     = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 149) == 0) rate_sel = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 1999) == 0) do_reset();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
